// File: rtl/mcbsp_master_tx_param_if.sv
// Word stream into the McBSP transmitter plus its serial clock/sync/data lines toward the DSP.
interface mcbsp_master_tx_param_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              mcbsp_master_clkr;
  logic              mcbsp_master_fsr;
  logic              mcbsp_master_miso;

  // master: word producer / serial observer; slave: the transmitter itself
  modport master (
    output s_valid, s_data,
    input  s_ready, mcbsp_master_clkr, mcbsp_master_fsr, mcbsp_master_miso
  );
  modport slave (
    input  s_valid, s_data,
    output s_ready, mcbsp_master_clkr, mcbsp_master_fsr, mcbsp_master_miso
  );
endinterface

// File: rtl/mcbsp_master_tx_param.sv
// Parametrised McBSP master transmitter: input FIFO, frame/word serialiser with gated bit clock,
// per-word or per-frame sync, inter-frame gap, continuous framing and sticky underrun.
module mcbsp_master_tx_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NWORD_W    = 9
) (
  input  logic                          mcbsp_clk_in,
  input  logic                          mcbsp_rst_in,
  input  logic [6:0]                    cfg_word_len,
  input  logic [NWORD_W-1:0]            cfg_frame_words,
  input  logic                          cfg_lsb_first,
  input  logic                          cfg_fs_per_frame,
  input  logic [7:0]                    cfg_gap,
  input  logic                          cfg_continuous,
  input  logic                          start,
  input  logic                          stop,
  mcbsp_master_tx_param_if.slave        bus,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [6:0]    WMAX     = 7'(DATA_W);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

  state_e              r_state, w_state_d;
  logic [6:0]          r_wl, w_wl_eff, r_bit_cnt, w_nxt_bit, w_idx;
  logic [NWORD_W-1:0]  r_fw, r_word_cnt, w_nxt_word;
  logic                r_lsb, r_fspf, r_cont;
  logic [7:0]          r_gap, r_gap_cnt, w_gap_cnt_d, w_gap_last;
  logic [DATA_W-1:0]   r_word, w_word_src, w_shifted;
  logic                r_clk_en, r_fsr, r_miso, r_frame_done, r_underrun, r_stop_seen;
  logic                w_clk_en_d, w_fsr_d, w_miso_d, w_frame_done_d;
  logic                w_load_cfg, w_clr_underrun, w_pop, w_new_word, w_drive;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr, r_rptr;
  logic [LW-1:0]       r_level, w_level_d;
  logic                r_s_ready, w_push, w_pop_fire, w_empty;

  assign w_empty    = (r_level == '0);
  assign w_push     = bus.s_valid && r_s_ready;
  assign w_pop_fire = w_pop && !w_empty;
  assign w_wl_eff   = (cfg_word_len == 7'd0 || cfg_word_len > WMAX) ? WMAX : cfg_word_len;
  assign w_gap_last = (r_gap == 8'd0) ? 8'd0 : r_gap - 8'd1;

  always_comb begin
    w_state_d      = r_state;
    w_load_cfg     = 1'b0;
    w_clr_underrun = 1'b0;
    w_pop          = 1'b0;
    w_new_word     = 1'b0;
    w_drive        = 1'b0;
    w_nxt_bit      = r_bit_cnt;
    w_nxt_word     = r_word_cnt;
    w_gap_cnt_d    = r_gap_cnt;
    w_clk_en_d     = 1'b0;
    w_fsr_d        = 1'b0;
    w_miso_d       = 1'b0;
    w_frame_done_d = 1'b0;
    w_word_src     = r_word;
    w_idx          = 7'd0;
    w_shifted      = '0;

    unique case (r_state)
      StIdle: begin
        if (start && cfg_frame_words != '0) begin
          w_state_d      = StLoad;
          w_load_cfg     = 1'b1;
          w_clr_underrun = 1'b1;
          w_clk_en_d     = 1'b1;
          w_fsr_d        = 1'b1;
        end
      end
      StLoad: begin
        w_state_d  = StShift;
        w_pop      = 1'b1;
        w_new_word = 1'b1;
        w_drive    = 1'b1;
        w_nxt_bit  = 7'd0;
        w_nxt_word = '0;
      end
      StShift: begin
        if (r_bit_cnt == r_wl - 7'd1) begin
          if (r_word_cnt == r_fw - NWORD_W'(1)) begin
            w_state_d      = StGap;
            w_gap_cnt_d    = 8'd0;
            w_frame_done_d = (w_gap_last == 8'd0);
          end else begin
            w_pop      = 1'b1;
            w_new_word = 1'b1;
            w_drive    = 1'b1;
            w_nxt_bit  = 7'd0;
            w_nxt_word = r_word_cnt + NWORD_W'(1);
          end
        end else begin
          w_drive   = 1'b1;
          w_nxt_bit = r_bit_cnt + 7'd1;
        end
      end
      StGap: begin
        if (r_gap_cnt == w_gap_last) begin
          // A stop landing on the exit edge itself still ends the run
          if (r_cont && !r_stop_seen && !stop && cfg_frame_words != '0) begin
            w_state_d  = StLoad;
            w_load_cfg = 1'b1;
            w_clk_en_d = 1'b1;
            w_fsr_d    = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end else begin
          w_gap_cnt_d    = r_gap_cnt + 8'd1;
          w_frame_done_d = (r_gap_cnt + 8'd1 == w_gap_last);
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_new_word) begin
      w_word_src = w_empty ? '0 : r_mem[r_rptr];
    end
    w_idx     = r_lsb ? w_nxt_bit : (r_wl - 7'd1 - w_nxt_bit);
    w_shifted = w_word_src >> w_idx;

    // Sync for the next word rides on the current word's last bit (1-bit data delay)
    if (w_drive) begin
      w_clk_en_d = 1'b1;
      w_miso_d   = w_shifted[0];
      w_fsr_d    = !r_fspf && (w_nxt_bit == r_wl - 7'd1) && (w_nxt_word != r_fw - NWORD_W'(1));
    end
  end

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop_fire})
      2'b10:   w_level_d = r_level + LW'(1);
      2'b01:   w_level_d = r_level - LW'(1);
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(negedge mcbsp_clk_in or posedge mcbsp_rst_in) begin
    if (mcbsp_rst_in) begin
      r_state      <= StIdle;
      r_wl         <= 7'd0;
      r_fw         <= '0;
      r_lsb        <= 1'b0;
      r_fspf       <= 1'b0;
      r_gap        <= 8'd0;
      r_cont       <= 1'b0;
      r_bit_cnt    <= 7'd0;
      r_word_cnt   <= '0;
      r_gap_cnt    <= 8'd0;
      r_word       <= '0;
      r_clk_en     <= 1'b0;
      r_fsr        <= 1'b0;
      r_miso       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      r_stop_seen  <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_s_ready    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load_cfg) begin
        r_wl   <= w_wl_eff;
        r_fw   <= cfg_frame_words;
        r_lsb  <= cfg_lsb_first;
        r_fspf <= cfg_fs_per_frame;
        r_gap  <= cfg_gap;
        r_cont <= cfg_continuous;
      end
      r_bit_cnt  <= w_nxt_bit;
      r_word_cnt <= w_nxt_word;
      r_gap_cnt  <= w_gap_cnt_d;
      if (w_new_word) begin
        r_word <= w_word_src;
      end
      r_clk_en     <= w_clk_en_d;
      r_fsr        <= w_fsr_d;
      r_miso       <= w_miso_d;
      r_frame_done <= w_frame_done_d;
      if (w_clr_underrun) begin
        r_underrun <= 1'b0;
      end else if (w_pop && w_empty) begin
        r_underrun <= 1'b1;
      end
      if (w_load_cfg) begin
        r_stop_seen <= 1'b0;
      end else if (stop && r_state != StIdle) begin
        r_stop_seen <= 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_fire) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_level   <= w_level_d;
      r_s_ready <= (w_level_d != LVL_FULL);
    end
  end

  always_ff @(negedge mcbsp_clk_in) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.s_data;
    end
  end

  assign bus.s_ready           = r_s_ready;
  assign bus.mcbsp_master_clkr = mcbsp_clk_in & r_clk_en;
  assign bus.mcbsp_master_fsr  = r_fsr;
  assign bus.mcbsp_master_miso = r_miso;
  assign busy                  = (r_state != StIdle);
  assign frame_done            = r_frame_done;
  assign underrun              = r_underrun;
  assign fifo_level            = r_level;

endmodule
